async_fifo_ex: RTL and testbench

Parametrised dual-clock FIFO for moving data words between independent write and read clock domains, e.g. 90 MHz producer to 65 MHz consumer. It uses Gray-coded pointers with a configurable synchronizer depth. It adds the following:
- fill counts in both domains
- programmable almost-full and almost-empty flags
- an optional first-word-fall-through (FWFT) read mode
- sticky overflow and underflow error flags

---
 rtl/async_fifo_ex.sv | 181 ++++++++++++++++++
 tb/tb_async_fifo_ex.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_ex.sv
// Dual-clock FIFO with Gray-coded pointer crossing, per-domain fill counts,
// almost-full/almost-empty flags, sticky error flags and optional FWFT output.
module async_fifo_ex #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FWFT        = 0,
  parameter int AF_THRESH   = (1 << ADDR_WIDTH) - 2,
  parameter int AE_THRESH   = 2
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_full,
  output logic                  wr_almost_full,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  wr_overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_empty,
  output logic                  rd_almost_empty,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic                  rd_underflow
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] AF_P    = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_P    = PW'(AE_THRESH);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = '0;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Handshake: a write is taken on a wr_clk edge where wr_en && !wr_full; a
  // read (standard) or acknowledge (FWFT) is taken on a rd_clk edge where
  // rd_en && !rd_empty. Requests against a full/empty FIFO are dropped and
  // only raise the matching sticky error flag.

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------- write domain ----------------
  logic [PW-1:0]                  wr_ptr_bin;
  logic [PW-1:0]                  wr_ptr_gray;
  logic [PW-1:0]                  wr_ptr_bin_nxt;
  logic [SYNC_STAGES-1:0][PW-1:0] rd_gray_sync;
  logic                           wr_accept;

  // Read pointer Gray copy, declared here because the write side samples it.
  logic [PW-1:0]                  rd_ptr_gray;

  assign wr_accept      = wr_en && !wr_full;
  assign wr_ptr_bin_nxt = wr_ptr_bin + PW'(1);

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wr_ptr_bin  <= '0;
      wr_ptr_gray <= '0;
      wr_overflow <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_bin  <= wr_ptr_bin_nxt;
        wr_ptr_gray <= bin2gray(wr_ptr_bin_nxt);
      end
      if (wr_en && wr_full) begin
        wr_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_accept) begin
      mem[wr_ptr_bin[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      rd_gray_sync <= '0;
    end else begin
      rd_gray_sync <= {rd_gray_sync[SYNC_STAGES-2:0], rd_ptr_gray};
    end
  end

  // The synchronized read pointer lags, so this count can only over-report.
  always_comb begin
    wr_count       = wr_ptr_bin - gray2bin(rd_gray_sync[SYNC_STAGES-1]);
    wr_full        = (wr_count == DEPTH_P);
    wr_almost_full = (wr_count >= AF_P);
  end

  // ---------------- read domain ----------------
  logic [PW-1:0]                  rd_ptr_bin;
  logic [SYNC_STAGES-1:0][PW-1:0] wr_gray_sync;
  logic [PW-1:0]                  mem_count;
  logic                           mem_empty;
  logic                           rd_load;
  logic                           rd_valid_q;
  logic                           rd_valid_nxt;
  logic [DATA_WIDTH-1:0]          rd_data_q;
  logic [PW-1:0]                  rd_ptr_bin_nxt;

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      wr_gray_sync <= '0;
    end else begin
      wr_gray_sync <= {wr_gray_sync[SYNC_STAGES-2:0], wr_ptr_gray};
    end
  end

  assign mem_count      = gray2bin(wr_gray_sync[SYNC_STAGES-1]) - rd_ptr_bin;
  assign mem_empty      = (mem_count == '0);
  assign rd_ptr_bin_nxt = rd_ptr_bin + PW'(1);

  // In FWFT mode the output register prefetches whenever it is free or
  // being acknowledged, which sustains one word per cycle.
  always_comb begin
    rd_load      = 1'b0;
    rd_valid_nxt = rd_valid_q;
    if (FWFT != 0) begin
      rd_load = !mem_empty && (!rd_valid_q || rd_en);
      if (rd_load) begin
        rd_valid_nxt = 1'b1;
      end else if (rd_en) begin
        rd_valid_nxt = 1'b0;
      end
    end else begin
      rd_load      = rd_en && !mem_empty;
      rd_valid_nxt = rd_load;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_ptr_bin   <= '0;
      rd_ptr_gray  <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_underflow <= 1'b0;
    end else begin
      if (rd_load) begin
        rd_ptr_bin  <= rd_ptr_bin_nxt;
        rd_ptr_gray <= bin2gray(rd_ptr_bin_nxt);
        rd_data_q   <= mem[rd_ptr_bin[ADDR_WIDTH-1:0]];
      end
      rd_valid_q <= rd_valid_nxt;
      if (rd_en && rd_empty) begin
        rd_underflow <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_data  = rd_data_q;
    rd_valid = rd_valid_q;
    if (FWFT != 0) begin
      rd_empty = !rd_valid_q;
      rd_count = mem_count + {{ADDR_WIDTH{1'b0}}, rd_valid_q};
    end else begin
      rd_empty = mem_empty;
      rd_count = mem_count;
    end
    rd_almost_empty = (rd_count <= AE_P);
  end

endmodule

// File: tb/tb_async_fifo_ex.sv
// Bench for async_fifo_ex: one standard-mode and one FWFT instance, a queue
// model of the stored words, and monitors that check data order and count bounds.
`timescale 1ns/10ps
module tb_async_fifo_ex;

  localparam int DW       = 8;
  localparam int AW       = 4;
  localparam int DEPTH    = 16;
  localparam int AF       = 14;
  localparam int AE       = 2;
  localparam int N_STRESS = 1000;
  localparam int BUDGET   = 8000;

  logic wr_clk = 1'b0;
  logic rd_clk = 1'b0;
  logic wr_rst_n;
  logic rd_rst_n;

  logic [1:0]         wr_en;
  logic [1:0]         rd_en;
  logic [1:0][DW-1:0] wr_data;
  logic [1:0][DW-1:0] rd_data;
  logic [1:0]         wr_full, wr_af, wr_ovf;
  logic [1:0]         rd_valid, rd_empty, rd_ae, rd_unf;
  logic [1:0][AW:0]   wr_count, rd_count;

  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int total;
  int bad;
  int rx_cnt [2];

  // ---------------- clock / reset ----------------
  initial forever #5.5 wr_clk = ~wr_clk;
  initial begin
    #0.3;
    forever #7.75 rd_clk = ~rd_clk;
  end

  for (genvar g = 0; g < 2; g++) begin : g_dut
    async_fifo_ex #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .SYNC_STAGES(2),
      .FWFT       (g),
      .AF_THRESH  (AF),
      .AE_THRESH  (AE)
    ) u_dut (
      .rd_clk         (rd_clk),
      .rd_rst_n       (rd_rst_n),
      .wr_clk         (wr_clk),
      .wr_rst_n       (wr_rst_n),
      .wr_en          (wr_en[g]),
      .wr_data        (wr_data[g]),
      .wr_full        (wr_full[g]),
      .wr_almost_full (wr_af[g]),
      .wr_count       (wr_count[g]),
      .wr_overflow    (wr_ovf[g]),
      .rd_en          (rd_en[g]),
      .rd_data        (rd_data[g]),
      .rd_valid       (rd_valid[g]),
      .rd_empty       (rd_empty[g]),
      .rd_almost_empty(rd_ae[g]),
      .rd_count       (rd_count[g]),
      .rd_underflow   (rd_unf[g])
    );
  end

  // ---------------- scoreboard helpers ----------------
  function automatic int q_size(input int m);
    return (m == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic q_push(input int m, input logic [DW-1:0] d);
    if (m == 0) exp_q0.push_back(d);
    else exp_q1.push_back(d);
  endtask

  function automatic logic [DW-1:0] q_pop(input int m);
    if (m == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  // Read side: count bound first, then take the word the DUT presents.
  always @(negedge rd_clk) begin
    if (rd_rst_n && wr_rst_n) begin
      for (int m = 0; m < 2; m++) begin
        total++;
        if (int'(rd_count[m]) > q_size(m)) begin
          bad++;
          $display("FAIL m%0d rd_count_bound: rd_count=%0d true_fill=%0d", m, rd_count[m], q_size(m));
        end
        if (rd_valid[m] && (m == 0 || rd_en[m])) begin
          total++;
          if (q_size(m) == 0) begin
            bad++;
            $display("FAIL m%0d unexpected_word: got %0h with nothing expected", m, rd_data[m]);
          end else begin
            logic [DW-1:0] e;
            e = q_pop(m);
            rx_cnt[m]++;
            if (rd_data[m] != e) begin
              bad++;
              $display("FAIL m%0d rd_data_order: got %0h expected %0h", m, rd_data[m], e);
            end
          end
        end
      end
    end
  end

  // Write side: memory fill never under-reported; the FWFT output register
  // holds one extra word that the write view does not count.
  always @(negedge wr_clk) begin
    if (rd_rst_n && wr_rst_n) begin
      for (int m = 0; m < 2; m++) begin
        total++;
        if (int'(wr_count[m]) + m < q_size(m)) begin
          bad++;
          $display("FAIL m%0d wr_count_bound: wr_count=%0d true_fill=%0d", m, wr_count[m], q_size(m));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_word(input int m, input logic [DW-1:0] d, input bit accept);
    wr_en[m]   = 1'b1;
    wr_data[m] = d;
    @(posedge wr_clk);
    if (accept) q_push(m, d);
    #1;
    wr_en[m] = 1'b0;
  endtask

  task automatic drain(input int m);
    for (int c = 0; c < 300 && q_size(m) > 0; c++) begin
      rd_en[m] = !rd_empty[m];
      @(posedge rd_clk);
      #1;
    end
    rd_en[m] = 1'b0;
    check($sformatf("m%0d drain_left", m), q_size(m), 0);
  endtask

  task automatic apply_reset();
    wr_en = '0;
    rd_en = '0;
    @(posedge wr_clk);
    #1;
    wr_rst_n = 1'b0;
    rd_rst_n = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    #2;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("m%0d rst_wr_full", m), int'(wr_full[m]), 0);
      check($sformatf("m%0d rst_wr_af", m), int'(wr_af[m]), 0);
      check($sformatf("m%0d rst_wr_count", m), int'(wr_count[m]), 0);
      check($sformatf("m%0d rst_wr_ovf", m), int'(wr_ovf[m]), 0);
      check($sformatf("m%0d rst_rd_data", m), int'(rd_data[m]), 0);
      check($sformatf("m%0d rst_rd_valid", m), int'(rd_valid[m]), 0);
      check($sformatf("m%0d rst_rd_empty", m), int'(rd_empty[m]), 1);
      check($sformatf("m%0d rst_rd_ae", m), int'(rd_ae[m]), 1);
      check($sformatf("m%0d rst_rd_count", m), int'(rd_count[m]), 0);
      check($sformatf("m%0d rst_rd_unf", m), int'(rd_unf[m]), 0);
    end
    repeat (3) @(posedge rd_clk);
    @(posedge wr_clk);
    #1;
    wr_rst_n = 1'b1;
    rd_rst_n = 1'b1;
    @(posedge wr_clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic fill_test(input int m);
    for (int n = 1; n <= DEPTH; n++) begin
      write_word(m, DW'(n - 1), 1'b1);
      if (m == 0) begin
        @(negedge wr_clk);
        check($sformatf("m0 fill_count_%0d", n), int'(wr_count[0]), n);
        check($sformatf("m0 fill_af_%0d", n), int'(wr_af[0]), (n >= AF) ? 1 : 0);
      end
    end
    repeat (10) @(posedge wr_clk);
    #1;
    if (m == 1) begin
      // One word already sits in the output register, so one more fits.
      check("m1 fill_not_full_yet", int'(wr_full[1]), 0);
      check("m1 fill_count_15", int'(wr_count[1]), DEPTH - 1);
      write_word(1, 8'h10, 1'b1);
      @(negedge wr_clk);
    end
    check($sformatf("m%0d fill_full", m), int'(wr_full[m]), 1);
    check($sformatf("m%0d fill_count", m), int'(wr_count[m]), DEPTH);
    check($sformatf("m%0d fill_af", m), int'(wr_af[m]), 1);
    check($sformatf("m%0d ovf_before", m), int'(wr_ovf[m]), 0);
    write_word(m, 8'hAA, 1'b0);
    @(negedge wr_clk);
    check($sformatf("m%0d ovf_after", m), int'(wr_ovf[m]), 1);
    check($sformatf("m%0d full_after_drop", m), int'(wr_full[m]), 1);
    repeat (6) @(posedge rd_clk);
    #1;
    check($sformatf("m%0d full_rd_count", m), int'(rd_count[m]), DEPTH + m);
    check($sformatf("m%0d full_rd_ae", m), int'(rd_ae[m]), 0);
    drain(m);
    repeat (10) @(posedge wr_clk);
    #1;
    check($sformatf("m%0d drained_rd_empty", m), int'(rd_empty[m]), 1);
    check($sformatf("m%0d drained_rd_count", m), int'(rd_count[m]), 0);
    check($sformatf("m%0d drained_wr_full", m), int'(wr_full[m]), 0);
    check($sformatf("m%0d drained_wr_count", m), int'(wr_count[m]), 0);
    check($sformatf("m%0d drained_ovf_sticky", m), int'(wr_ovf[m]), 1);
  endtask

  task automatic latency_underflow_test(input int m);
    int k;
    k = 0;
    fork
      write_word(m, 8'h5C, 1'b1);
      begin
        @(posedge wr_clk);
        for (k = 1; k <= 8; k++) begin
          @(posedge rd_clk);
          #0.5;
          if (!rd_empty[m]) break;
        end
      end
    join
    total++;
    if (k > 3 + m) begin
      bad++;
      $display("FAIL m%0d first_word_latency: got %0d rd edges allowed %0d", m, k, 3 + m);
    end
    if (m == 0) begin
      rd_en[0] = 1'b1;
      @(posedge rd_clk);
      #1;
      rd_en[0] = 1'b0;
      check("m0 lat_rd_valid", int'(rd_valid[0]), 1);
      check("m0 lat_rd_data", int'(rd_data[0]), 8'h5C);
      @(posedge rd_clk);
      #1;
      check("m0 lat_valid_one_cycle", int'(rd_valid[0]), 0);
      check("m0 lat_data_hold", int'(rd_data[0]), 8'h5C);
    end else begin
      check("m1 fwft_rd_valid", int'(rd_valid[1]), 1);
      check("m1 fwft_rd_data", int'(rd_data[1]), 8'h5C);
      repeat (2) @(posedge rd_clk);
      #1;
      check("m1 fwft_hold_valid", int'(rd_valid[1]), 1);
      rd_en[1] = 1'b1;
      @(posedge rd_clk);
      #1;
      rd_en[1] = 1'b0;
      check("m1 fwft_ack_valid", int'(rd_valid[1]), 0);
      check("m1 fwft_ack_empty", int'(rd_empty[1]), 1);
    end
    check($sformatf("m%0d unf_before", m), int'(rd_unf[m]), 0);
    rd_en[m] = 1'b1;
    @(posedge rd_clk);
    #1;
    rd_en[m] = 1'b0;
    check($sformatf("m%0d unf_set", m), int'(rd_unf[m]), 1);
    check($sformatf("m%0d unf_no_valid", m), int'(rd_valid[m]), 0);
    if (m == 0) check("m0 unf_data_hold", int'(rd_data[0]), 8'h5C);
    repeat (5) @(posedge rd_clk);
    #1;
    check($sformatf("m%0d unf_sticky", m), int'(rd_unf[m]), 1);
  endtask

  task automatic thresh_test(input int m);
    for (int n = 1; n <= 4; n++) begin
      write_word(m, DW'($urandom), 1'b1);
      repeat (6) @(posedge rd_clk);
      #1;
      check($sformatf("m%0d th_rd_count_%0d", m, n), int'(rd_count[m]), n);
      check($sformatf("m%0d th_rd_ae_%0d", m, n), int'(rd_ae[m]), (n <= AE) ? 1 : 0);
      check($sformatf("m%0d th_rd_empty_%0d", m, n), int'(rd_empty[m]), 0);
    end
    drain(m);
  endtask

  task automatic stress_test(input int m);
    rx_cnt[m] = 0;
    fork
      begin : wr_side
        int sent;
        int p;
        sent = 0;
        for (int c = 0; c < BUDGET && sent < N_STRESS; c++) begin
          p = (sent < N_STRESS / 2) ? 80 : 40;
          if ($urandom_range(0, 99) < p && !wr_full[m]) begin
            write_word(m, DW'($urandom), 1'b1);
            sent++;
          end else begin
            @(posedge wr_clk);
            #1;
          end
        end
      end
      begin : rd_side
        int p;
        for (int c = 0; c < BUDGET && rx_cnt[m] < N_STRESS; c++) begin
          p = (rx_cnt[m] < N_STRESS / 2) ? 35 : 90;
          rd_en[m] = ($urandom_range(0, 99) < p);
          @(posedge rd_clk);
          #1;
        end
        rd_en[m] = 1'b0;
      end
    join
    check($sformatf("m%0d stress_received", m), rx_cnt[m], N_STRESS);
    check($sformatf("m%0d stress_left", m), q_size(m), 0);
  endtask

  task automatic reset_mid_test(input int m);
    for (int i = 0; i < 7; i++) write_word(m, DW'(8'h70 + i), 1'b1);
    repeat (4) @(posedge rd_clk);
    #1;
    apply_reset();
    for (int i = 1; i <= 3; i++) write_word(m, DW'(i), 1'b1);
    repeat (6) @(posedge rd_clk);
    #1;
    check($sformatf("m%0d post_rst_count", m), int'(rd_count[m]), 3);
    rx_cnt[m] = 0;
    drain(m);
    check($sformatf("m%0d post_rst_received", m), rx_cnt[m], 3);
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    total    = 0;
    bad      = 0;
    rx_cnt   = '{0, 0};
    wr_rst_n = 1'b0;
    rd_rst_n = 1'b0;
    wr_en    = '0;
    rd_en    = '0;
    wr_data  = '0;
    for (int m = 0; m < 2; m++) begin
      apply_reset();
      fill_test(m);
      apply_reset();
      latency_underflow_test(m);
      apply_reset();
      thresh_test(m);
      apply_reset();
      stress_test(m);
      apply_reset();
      reset_mid_test(m);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
